// File: rtl/transceiver.sv
// Weather-station radio front end: hour-of-day counter, daily transmit window,
// and registered 3-bit weather symbol driven only while the window is open.
module transceiver #(
  parameter int CYCLES_PER_HOUR = 100,
  parameter int RESET_HOUR      = 0,
  parameter int EN_START        = 6,
  parameter int EN_END          = 22,
  parameter int HOT_T           = 35,
  parameter int COLD_T          = 5,
  parameter int HUMID_H         = 50,
  parameter int WIND_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] temperature,
  input  logic [5:0] humidity,
  input  logic [4:0] wind,
  output logic [4:0] current_hour,
  output logic       enable_transceiver,
  output logic [2:0] signal
);

  localparam int PW = $clog2(CYCLES_PER_HOUR);
  localparam logic [PW-1:0] TC_V  = PW'(CYCLES_PER_HOUR - 1);
  localparam logic [4:0] RST_HOUR = 5'(RESET_HOUR);
  localparam logic [4:0] START_V  = 5'(EN_START);
  localparam logic [4:0] END_V    = 5'(EN_END);
  localparam logic [5:0] HOT_V    = 6'(HOT_T);
  localparam logic [5:0] COLD_V   = 6'(COLD_T);
  localparam logic [5:0] HUMID_V  = 6'(HUMID_H);
  localparam logic [4:0] WIND_V   = 5'(WIND_W);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  logic          en_q, en_d;
  logic [2:0]    sig_q, sig_d;
  logic [2:0]    cls;
  logic          tc;

  function automatic logic win(input logic [4:0] h);
    return (h >= START_V) && (h < END_V);
  endfunction

  always_comb begin
    cls = 3'b001;
    if ((wind >= WIND_V) && (humidity >= HUMID_V)) cls = 3'b110;
    else if (wind >= WIND_V)                       cls = 3'b101;
    else if (humidity >= HUMID_V)                  cls = 3'b100;
    else if (temperature >= HOT_V)                 cls = 3'b010;
    else if (temperature <= COLD_V)                cls = 3'b011;
  end

  // Enable and symbol follow the window of the hour being loaded this edge,
  // so enable never lags current_hour.
  always_comb begin
    tc      = (presc_q == TC_V);
    presc_d = tc ? '0 : presc_q + PW'(1);
    hour_d  = hour_q;
    if (tc) hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
    en_d    = win(hour_d);
    sig_d   = en_d ? cls : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      hour_q  <= RST_HOUR;
      en_q    <= win(RST_HOUR);
      sig_q   <= '0;
    end else begin
      presc_q <= presc_d;
      hour_q  <= hour_d;
      en_q    <= en_d;
      sig_q   <= sig_d;
    end
  end

  always_comb begin
    current_hour       = hour_q;
    enable_transceiver = en_q;
    signal             = sig_q;
  end

endmodule

// File: tb/tb_transceiver.sv
// Scoreboard bench for transceiver: four instances with different hour/reset
// parameters share the sensor inputs and are checked every cycle.
module tb_transceiver;

  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [5:0] temperature, humidity;
  logic [4:0] wind;
  logic [4:0] hr  [4];
  logic       en  [4];
  logic [2:0] sig [4];

  always #5 clk = ~clk;

  transceiver #(.CYCLES_PER_HOUR(100), .RESET_HOUR(12)) u_a (
    .clk(clk), .rst(rst[0]), .temperature(temperature), .humidity(humidity), .wind(wind),
    .current_hour(hr[0]), .enable_transceiver(en[0]), .signal(sig[0]));
  transceiver #(.CYCLES_PER_HOUR(100), .RESET_HOUR(4)) u_b (
    .clk(clk), .rst(rst[1]), .temperature(temperature), .humidity(humidity), .wind(wind),
    .current_hour(hr[1]), .enable_transceiver(en[1]), .signal(sig[1]));
  transceiver #(.CYCLES_PER_HOUR(4), .RESET_HOUR(21)) u_c (
    .clk(clk), .rst(rst[2]), .temperature(temperature), .humidity(humidity), .wind(wind),
    .current_hour(hr[2]), .enable_transceiver(en[2]), .signal(sig[2]));
  transceiver #(.CYCLES_PER_HOUR(4), .RESET_HOUR(0)) u_d (
    .clk(clk), .rst(rst[3]), .temperature(temperature), .humidity(humidity), .wind(wind),
    .current_hour(hr[3]), .enable_transceiver(en[3]), .signal(sig[3]));

  typedef struct {int inst; int hour; int en; int sig;} exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int m_presc [4];
  int m_hour  [4];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cph_of(input int i);
    return (i < 2) ? 100 : 4;
  endfunction

  function automatic int rh_of(input int i);
    case (i)
      0:       return 12;
      1:       return 4;
      2:       return 21;
      default: return 0;
    endcase
  endfunction

  function automatic int classify(input int t, input int h, input int w);
    bit hot, cold, hum, wnd;
    hot  = (t >= 35);
    cold = (t <= 5);
    hum  = (h >= 50);
    wnd  = (w >= 20);
    if (wnd) return hum ? 6 : 5;
    if (hum) return 4;
    if (hot) return 2;
    if (cold) return 3;
    return 1;
  endfunction

  // Advance the reference by one edge, push expectations, clock, then compare.
  task automatic step();
    exp_t e;
    int   w;
    for (int i = 0; i < 4; i++) begin
      if (rst[i]) begin
        m_presc[i] = 0;
        m_hour[i]  = rh_of(i);
      end else if (m_presc[i] == cph_of(i) - 1) begin
        m_presc[i] = 0;
        m_hour[i]  = (m_hour[i] + 1) % 24;
      end else begin
        m_presc[i] = m_presc[i] + 1;
      end
      w     = (m_hour[i] >= 6 && m_hour[i] < 22) ? 1 : 0;
      e.inst = i;
      e.hour = m_hour[i];
      e.en   = w;
      e.sig  = (w == 1 && !rst[i]) ? classify(temperature, humidity, wind) : 0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("hour%0d", e.inst), int'(hr[e.inst]), e.hour);
      check($sformatf("en%0d", e.inst), int'(en[e.inst]), e.en);
      check($sformatf("sig%0d", e.inst), int'(sig[e.inst]), e.sig);
    end
  endtask

  typedef struct {int t; int h; int w; int code;} vec_t;
  vec_t tbl[$];

  initial begin
    tbl = '{'{40,30,10,2}, '{20,55,10,4}, '{20,30,25,5}, '{20,55,25,6},
            '{3,30,10,3},  '{35,30,10,2}, '{34,30,10,1}, '{5,30,10,3},
            '{6,30,10,1},  '{20,50,19,4}, '{20,49,20,5}, '{63,63,31,6},
            '{0,0,0,3},    '{40,55,10,4}, '{20,30,10,1}};

    rst = '1;
    temperature = 6'd20;
    humidity    = 6'd30;
    wind        = 5'd10;
    step();
    step();
    check("rst_h_d", int'(hr[3]), 0);
    check("rst_en_d", int'(en[3]), 0);
    check("rst_sig_d", int'(sig[3]), 0);
    rst = '0;

    repeat (10) step();
    check("open_en", int'(en[0]), 1);
    check("open_sig", int'(sig[0]), 1);
    check("closed_h", int'(hr[1]), 4);
    check("closed_en", int'(en[1]), 0);

    foreach (tbl[k]) begin
      temperature = 6'(tbl[k].t);
      humidity    = 6'(tbl[k].h);
      wind        = 5'(tbl[k].w);
      step();
      check($sformatf("cls%0d", k), int'(sig[0]), tbl[k].code);
      check($sformatf("closed_sig%0d", k), int'(sig[1]), 0);
    end

    repeat (60) begin
      temperature = 6'($urandom_range(0, 63));
      humidity    = 6'($urandom_range(0, 63));
      wind        = 5'($urandom_range(0, 31));
      step();
    end

    begin : wait_h12
      bit hit = 0;
      for (int n = 0; n < 200 && !hit; n++) begin
        if (m_hour[3] == 12 && m_presc[3] == 1) hit = 1;
        else step();
      end
      check("reach_h12", int'(hit), 1);
    end
    check("pre_rst_en", int'(en[3]), 1);

    rst[3] = 1'b1;
    step();
    rst[3] = 1'b0;
    check("mid_rst_h", int'(hr[3]), 0);
    check("mid_rst_en", int'(en[3]), 0);
    check("mid_rst_sig", int'(sig[3]), 0);
    repeat (3) step();
    check("restart_h0", int'(hr[3]), 0);
    step();
    check("restart_h1", int'(hr[3]), 1);

    repeat (120) begin
      temperature = 6'($urandom_range(0, 63));
      humidity    = 6'($urandom_range(0, 63));
      wind        = 5'($urandom_range(0, 31));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
